// File: rtl/mult_div_unit_if.sv
// Execute-stage bus of the multiply/divide unit: decoded instruction and operands in,
// HI/LO state, read data and handshake flags out.
interface mult_div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  i_start;
    logic [2:0]            i_alu_op;
    logic [5:0]            i_alu_function;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic [DATA_WIDTH-1:0] i_data_b;
    logic [DATA_WIDTH-1:0] o_hi;
    logic [DATA_WIDTH-1:0] o_lo;
    logic [DATA_WIDTH-1:0] o_md_result;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_stall;

    modport master (
        output i_start, i_alu_op, i_alu_function, i_data_a, i_data_b,
        input  o_hi, o_lo, o_md_result, o_busy, o_done, o_stall
    );

    modport slave (
        input  i_start, i_alu_op, i_alu_function, i_data_a, i_data_b,
        output o_hi, o_lo, o_md_result, o_busy, o_done, o_stall
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; shift-add multiply, restoring divide.
// Define MDU_DIVIDER_EN to compile in the divider datapath and DIV/DIVU decode.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    mult_div_unit_if.slave      md
);
    localparam int unsigned W        = DATA_WIDTH;
    localparam int unsigned CntWidth = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e                r_state, w_state_next;
    logic [CntWidth-1:0]   r_cnt;
    logic [W-1:0]          r_hi, r_lo;
    logic                  r_done;
    logic [2*W-1:0]        r_acc;
    logic [W-1:0]          r_opnd;
    logic                  r_sign_a, r_sign_b;

    logic                  w_rtype, w_signed;
    logic                  w_mult, w_div, w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic                  w_accept, w_last;
    logic                  w_sign_a, w_sign_b;
    logic [W-1:0]          w_mag_a, w_mag_b;
    logic [W:0]            w_mul_sum;
    logic [2*W-1:0]        w_mul_next, w_prod;
    logic [W-1:0]          w_fix_hi, w_fix_lo;

`ifdef MDU_DIVIDER_EN
    logic                  r_is_div;
    logic [W-1:0]          r_rem;
    logic [W:0]            w_div_shift, w_div_diff;
`endif

    assign w_rtype = (md.i_alu_op == 3'b111);

    always_comb begin
        w_mult   = 1'b0;
        w_div    = 1'b0;
        w_mfhi   = 1'b0;
        w_mflo   = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        w_signed = 1'b0;
        if (w_rtype) begin
            case (md.i_alu_function)
                6'b011000: begin w_mult = 1'b1; w_signed = 1'b1; end
                6'b011001: w_mult = 1'b1;
`ifdef MDU_DIVIDER_EN
                6'b011010: begin w_div = 1'b1; w_signed = 1'b1; end
                6'b011011: w_div = 1'b1;
`endif
                6'b010000: w_mfhi = 1'b1;
                6'b010010: w_mflo = 1'b1;
                6'b010001: w_mthi = 1'b1;
                6'b010011: w_mtlo = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_accept = md.i_start & (w_mult | w_div) & (r_state == StIdle);
    assign w_last   = (r_cnt == CntWidth'(W - 1));
    assign w_sign_a = w_signed & md.i_data_a[W-1];
    assign w_sign_b = w_signed & md.i_data_b[W-1];
    assign w_mag_a  = w_sign_a ? -md.i_data_a : md.i_data_a;
    assign w_mag_b  = w_sign_b ? -md.i_data_b : md.i_data_b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

`ifdef MDU_DIVIDER_EN
    // Divide: acc low half shifts the dividend out and the quotient in.
    assign w_div_shift = {r_rem, r_acc[W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
`endif

    always_comb begin
        w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        w_fix_hi = w_prod[2*W-1:W];
        w_fix_lo = w_prod[W-1:0];
`ifdef MDU_DIVIDER_EN
        if (r_is_div) begin
            if (r_opnd == '0) begin
                // Remainder holds |DataA| here, so re-applying signA restores raw DataA.
                w_fix_lo = '1;
                w_fix_hi = r_sign_a ? -r_rem : r_rem;
            end else begin
                w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc[W-1:0] : r_acc[W-1:0];
                w_fix_hi = r_sign_a ? -r_rem : r_rem;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StFix;
            StFix:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        md.o_busy      = (r_state != StIdle);
        md.o_done      = r_done;
        md.o_stall     = md.i_start & (r_state != StIdle) &
                         (w_mult | w_div | w_mfhi | w_mflo | w_mthi | w_mtlo);
        md.o_md_result = w_mfhi ? r_hi : r_lo;
        md.o_hi        = r_hi;
        md.o_lo        = r_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
`ifdef MDU_DIVIDER_EN
            r_is_div <= 1'b0;
            r_rem    <= '0;
`endif
        end else begin
            r_done <= (r_state == StFix);
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_opnd   <= w_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{W{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
`ifdef MDU_DIVIDER_EN
                        r_is_div <= w_div;
                        r_rem    <= '0;
`endif
                    end else if (md.i_start) begin
                        if (w_mthi) r_hi <= md.i_data_a;
                        if (w_mtlo) r_lo <= md.i_data_a;
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + CntWidth'(1);
`ifdef MDU_DIVIDER_EN
                    if (r_is_div) begin
                        r_rem        <= w_div_diff[W] ? w_div_shift[W-1:0] : w_div_diff[W-1:0];
                        r_acc[W-1:0] <= {r_acc[W-2:0], ~w_div_diff[W]};
                    end else begin
                        r_acc <= w_mul_next;
                    end
`else
                    r_acc <= w_mul_next;
`endif
                end
                StFix: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, HI/LO results, stall, MT/MF, reset.
module tb_mult_div_unit;
    localparam int unsigned DW = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.DATA_WIDTH(DW)) md ();

    mult_div_unit #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        md.i_start        = 1'b1;
        md.i_alu_op       = 3'b111;
        md.i_alu_function = fn;
        md.i_data_a       = a;
        md.i_data_b       = b;
    endtask

    task automatic idle();
        md.i_start        = 1'b0;
        md.i_alu_op       = 3'b000;
        md.i_alu_function = 6'b000000;
    endtask

    // Issue an op in the current cycle, expect Done 33 edges after acceptance.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp_hi,
                          input logic [DW-1:0] exp_lo);
        int k;
        issue(fn, a, b);
        tick();
        idle();
        check({tag, "_busy"}, {31'd0, md.o_busy}, 32'd1);
        check({tag, "_done_low"}, {31'd0, md.o_done}, 32'd0);
        for (k = 1; k <= 100; k++) begin
            tick();
            if (md.o_done) break;
        end
        check({tag, "_latency"}, DW'(k), 32'd33);
        check({tag, "_busy_at_done"}, {31'd0, md.o_busy}, 32'd0);
        check({tag, "_hi"}, md.o_hi, exp_hi);
        check({tag, "_lo"}, md.o_lo, exp_lo);
    endtask

    initial begin
        int  k;
        logic bad;
        logic seen_done;

        idle();
        md.i_data_a = '0;
        md.i_data_b = '0;
        reset = 1'b1;
        #12;
        check("reset_hi", md.o_hi, 32'd0);
        check("reset_lo", md.o_lo, 32'd0);
        check("reset_busy", {31'd0, md.o_busy}, 32'd0);
        check("reset_done", {31'd0, md.o_done}, 32'd0);
        reset = 1'b0;
        tick();

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        // Back-to-back: issued in the Done cycle of the previous op.
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        issue(F_MTLO, 32'h0000_1234, 32'd0);
        tick();
        idle();
        check("mtlo_lo", md.o_lo, 32'h0000_1234);
        check("mtlo_busy", {31'd0, md.o_busy}, 32'd0);
        issue(F_MTHI, 32'h0000_ABCD, 32'd0);
        tick();
        idle();
        check("mthi_hi", md.o_hi, 32'h0000_ABCD);
        check("mthi_busy", {31'd0, md.o_busy}, 32'd0);
        check("mthi_done", {31'd0, md.o_done}, 32'd0);

        // MULT 2*3 with an MFLO arriving at cycle 5 of the operation.
        issue(F_MULT, 32'd2, 32'd3);
        tick();
        idle();
        tick();
        tick();
        md.i_start        = 1'b1;
        md.i_alu_op       = 3'b000;
        md.i_alu_function = F_MULT;
        #1;
        check("non_rtype_no_stall", {31'd0, md.o_stall}, 32'd0);
        idle();
        tick();
        tick();
        issue(F_MFLO, 32'd0, 32'd0);
        #1;
        check("mflo_stall", {31'd0, md.o_stall}, 32'd1);
        check("mflo_old_value", md.o_md_result, 32'h0000_1234);
        bad = 1'b0;
        for (k = 5; k <= 100; k++) begin
            tick();
            if (md.o_done) break;
            if (!md.o_stall || md.o_md_result !== 32'h0000_1234) bad = 1'b1;
        end
        check("mflo_held_while_busy", {31'd0, bad}, 32'd0);
        check("mflo_done_reached", {31'd0, md.o_done}, 32'd1);
        check("mflo_stall_release", {31'd0, md.o_stall}, 32'd0);
        check("mflo_new_value", md.o_md_result, 32'd6);
        issue(F_MFHI, 32'd0, 32'd0);
        #1;
        check("mfhi_value", md.o_md_result, 32'd0);
        tick();
        idle();

`ifdef MDU_DIVIDER_EN
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", F_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_zero_neg", F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_basic", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
`else
        issue(F_DIVU, 32'd8, 32'd2);
        #1;
        check("divu_off_stall", {31'd0, md.o_stall}, 32'd0);
        tick();
        idle();
        check("divu_off_busy", {31'd0, md.o_busy}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md.o_done || md.o_busy) seen_done = 1'b1;
        end
        check("divu_off_no_activity", {31'd0, seen_done}, 32'd0);
        check("divu_off_hi", md.o_hi, 32'd0);
        check("divu_off_lo", md.o_lo, 32'd6);
`endif

        // Reset in the middle of a MULTU.
        issue(F_MTHI, 32'h0000_0055, 32'd0);
        tick();
        issue(F_MULTU, 32'd7, 32'd9);
        tick();
        idle();
        repeat (9) tick();
        check("pre_reset_busy", {31'd0, md.o_busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_hi", md.o_hi, 32'd0);
        check("async_reset_lo", md.o_lo, 32'd0);
        check("async_reset_busy", {31'd0, md.o_busy}, 32'd0);
        #1;
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (md.o_done) seen_done = 1'b1;
        end
        check("reset_no_done", {31'd0, seen_done}, 32'd0);
        check("reset_stays_idle", {31'd0, md.o_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
